cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead add/subtract unit with optional signed saturation and a built-in accumulator.
- Successor to the fixed 16-bit combinational CLA used in the autoencoder datapath: generic width, one pipeline stage per lookahead group, valid/ready flow control.
- Serves the neuron MAC path, summing products and bias in Q-format two's complement.

---
 rtl/cla_pipe_addsub.sv | 143 ++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead add/sub with saturation and accumulator.
// One pipeline stage per lookahead group, valid/ready on both sides.
module cla_pipe_addsub #(
  parameter int WIDTH    = 16,
  parameter int GROUP    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_out
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
    logic             c;
  } stg_t;

  stg_t             stg [NG];
  stg_t             nxt [NG];
  stg_t             ent;
  stg_t             fin;
  logic             stall;
  logic             acc_pend;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc_q;

  assign stall   = out_valid && !out_ready;
  assign acc_out = acc_q;

  always_comb begin
    acc_pend = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (stg[g].vld && stg[g].op[1]) acc_pend = 1'b1;
    end
  end

  assign in_ready = !rst && !stall &&
                    !(acc_pend && op == 2'b10);

  always_comb begin
    ent     = '0;
    ent.vld = in_valid && in_ready;
    ent.op  = op;
    unique case (op)
      2'b00: begin
        ent.x = in_a;
        ent.y = in_b;
      end
      2'b01: begin
        ent.x = in_a;
        ent.y = ~in_b;
        ent.c = 1'b1;
      end
      2'b10: begin
        ent.x = acc_q;
        ent.y = in_a;
      end
      2'b11: begin
        ent.x = in_a;
      end
    endcase
  end

  // group generate/propagate prefix gives every bit carry from the group cin
  always_comb begin
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] gn;
    logic [GROUP-1:0] s;
    logic             gg;
    logic             pp;
    for (int g = 0; g < NG; g++) begin
      nxt[g] = stg[g];
      p  = stg[g].x[g*GROUP +: GROUP] ^ stg[g].y[g*GROUP +: GROUP];
      gn = stg[g].x[g*GROUP +: GROUP] & stg[g].y[g*GROUP +: GROUP];
      s  = '0;
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        s[i] = p[i] ^ (gg | (pp & stg[g].c));
        gg   = gn[i] | (p[i] & gg);
        pp   = pp & p[i];
      end
      nxt[g].sum[g*GROUP +: GROUP] = s;
      nxt[g].c = gg | (pp & stg[g].c);
    end
  end

  assign fin = nxt[NG-1];

  always_comb begin
    ovf = (fin.op != 2'b11) &&
          (fin.x[MSB] == fin.y[MSB]) &&
          (fin.sum[MSB] != fin.x[MSB]);
    res = fin.sum;
    if (SATURATE && ovf) begin
      res = fin.x[MSB] ? {1'b1, {MSB{1'b0}}}
                       : {1'b0, {MSB{1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NG; g++) stg[g] <= '0;
    end else if (!stall) begin
      stg[0] <= ent;
      for (int g = 1; g < NG; g++) stg[g] <= nxt[g-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      acc_q     <= '0;
    end else if (!stall) begin
      out_valid <= fin.vld;
      if (fin.vld) begin
        out_sum <= res;
        out_ovf <= ovf;
        if (fin.op[1]) acc_q <= res;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed cases plus random traffic
// scored against an integer-arithmetic model (saturating and wrapping DUTs).
module tb_cla_pipe_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic         in_ready, out_valid, out_ovf;
  logic [W-1:0] out_sum, acc_out;
  logic         w_in_ready, w_out_valid, w_out_ovf;
  logic [W-1:0] w_out_sum, w_acc_out;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct {
    logic [16:0] s;
    logic [16:0] w;
    logic        accop;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] macc_s = '0;
  logic [W-1:0] macc_w = '0;

  always #5 clk = ~clk;

  cla_pipe_addsub dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf),
    .acc_out(acc_out)
  );

  cla_pipe_addsub #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .in_a(in_a), .in_b(in_b),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_sum(w_out_sum), .out_ovf(w_out_ovf),
    .acc_out(w_acc_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // true signed result, then clamp or wrap
  function automatic logic [16:0] ref_op(
    input logic [1:0] o, input logic [15:0] a,
    input logic [15:0] b, input logic [15:0] acc,
    input bit sat);
    int r;
    int sa;
    int sb;
    int sc;
    logic v;
    logic [15:0] q;
    sa = $signed(a);
    sb = $signed(b);
    sc = $signed(acc);
    case (o)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sc + sa;
      default: r = sa;
    endcase
    v = (r > 32767) || (r < -32768);
    if (v && sat) q = (r > 0) ? 16'h7fff : 16'h8000;
    else          q = r[15:0];
    return {v, q};
  endfunction

  always @(negedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      macc_s = '0;
      macc_w = '0;
    end else begin
      if (in_valid && in_ready) begin
        e.s = ref_op(op, in_a, in_b, macc_s, 1'b1);
        e.w = ref_op(op, in_a, in_b, macc_w, 1'b0);
        e.accop = op[1];
        if (op[1]) begin
          macc_s = e.s[15:0];
          macc_w = e.w[15:0];
        end
        exp_q.push_back(e);
        chk("w_rdy", 32'(w_in_ready), 1);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("sb_extra", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", 32'(out_sum), 32'(e.s[15:0]));
          chk("sb_ovf", 32'(out_ovf), 32'(e.s[16]));
          chk("sb_wsum", 32'(w_out_sum), 32'(e.w[15:0]));
          chk("sb_wovf", 32'(w_out_ovf), 32'(e.w[16]));
          chk("sb_wvld", 32'(w_out_valid), 1);
          if (e.accop) begin
            chk("sb_acc", 32'(acc_out), 32'(e.s[15:0]));
            chk("sb_wacc", 32'(w_acc_out), 32'(e.w[15:0]));
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, output int n);
    op = o;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("issue_tmo", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!out_valid && c < 50);
    if (!out_valid) chk("out_tmo", c, 0);
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] s, input logic v);
    int n;
    int c;
    issue(o, a, b, n);
    wait_out(c);
    chk({tag, "_sum"}, 32'(out_sum), 32'(s));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(v));
  endtask

  initial begin
    int c;
    int n;
    int n2;
    int base;
    int cnt;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_sum", 32'(out_sum), 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 1);

    issue(2'b00, 16'h1234, 16'h0101, n);
    wait_out(c);
    chk("t1_lat", c, 4);
    chk("t1_sum", 32'(out_sum), 32'h1335);
    chk("t1_ovf", 32'(out_ovf), 0);

    run("t2_pos", 2'b00, 16'h7000, 16'h2000, 16'h7fff, 1'b1);
    chk("t2_wsum", 32'(w_out_sum), 32'h9000);
    chk("t2_wovf", 32'(w_out_ovf), 1);
    run("t2_neg", 2'b00, 16'h9000, 16'h9000, 16'h8000, 1'b1);
    chk("t2_wneg", 32'(w_out_sum), 32'h2000);
    run("t3_sub", 2'b01, 16'h0005, 16'h0007, 16'hfffe, 1'b0);
    run("t3_min", 2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1);

    issue(2'b11, 16'h0010, 16'h0000, n);
    issue(2'b10, 16'h0003, 16'h0000, n);
    chk("t4_wait", n, 4);
    wait_out(c);
    chk("t4_sum", 32'(out_sum), 32'h0013);
    chk("t4_acc", 32'(acc_out), 32'h0013);
    issue(2'b11, 16'h0020, 16'h0000, n);
    issue(2'b00, 16'h0001, 16'h0002, n);
    chk("t4_nohaz", n, 0);
    repeat (8) @(posedge clk);
    #1;

    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(2'b00, 16'(i), 16'h0001, n2);
      end
      begin
        wait_out(c);
        chk("t5_first", 32'(out_sum), 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t5_rdy", 32'(in_ready), 0);
          chk("t5_hold", 32'(out_valid), 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("t5_count", n_out - base, 6);

    for (int i = 0; i < 4; i++) issue(2'b00, 16'(i + 1), 16'h0001, n);
    @(posedge clk);
    #1;
    chk("t6_pre_vld", 32'(out_valid), 1);
    chk("t6_pre_acc", 32'(acc_out), 32'h0020);
    rst = 1'b1;
    #1;
    chk("t6_vld", 32'(out_valid), 0);
    chk("t6_acc", 32'(acc_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    chk("t6_stale", cnt, 0);
    chk("t6_rdy", 32'(in_ready), 1);

    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
